updown_counter: RTL
===================

# updown_counter

Parametrised successor to the team's free-running 8-bit counter: width, modulus, reset value and overflow mode are generics, with direction control, synchronous load/clear, a count enable, a registered carry/borrow pulse and a sticky overflow flag. Used as the general-purpose event/timebase counter in datapath and timer logic. One clock domain, no sub-blocks.

## Interface

Reset is asynchronous and active-low. It keeps the codebase's port name `reset`, but `reset` = 0 means reset.

Parameters:
- `WIDTH`, 8: counter width in bits, 2 to 32.
- `MAX`, 2**WIDTH-1: top count value, 1 to 2**WIDTH-1. The count range is 0..MAX.
- `RESET_VALUE`, 0: value forced by `reset`. Must be ≤ MAX; elaboration error otherwise.
- `SATURATE`, 0: 0 means wrap at the boundaries, 1 means hold at the boundaries.

Ports:
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `clear`  in  1  synchronous clear to 0; also clears `ovf`.
- `load`  in  1  synchronous load of `load_value`.
- `load_value`  in  WIDTH  load data. Values above MAX are clamped to MAX.
- `en`  in  1  count enable.
- `up`  in  1  direction: 1 counts up, 0 counts down.
- `value`  out  WIDTH  current count, registered.
- `carry`  out  1  one-cycle pulse, registered, marking a boundary event.
- `ovf`  out  1  sticky boundary-event flag, registered.

## Operation

- Reset assertion (`reset` = 0), asynchronous: `value` = RESET_VALUE, `carry` = 0, `ovf` = 0. Takes effect immediately, including mid-count.
- Each rising edge with `reset` = 1 applies exactly one action, in priority order `clear` > `load` > `en`:
  - `clear`: `value` ← 0, `ovf` ← 0, `carry` ← 0.
  - `load`: `value` ← min(`load_value`, MAX), `carry` ← 0. `ovf` is unchanged.
  - `en` with `up` = 1:
    - If `value` < MAX: `value` + 1.
    - If `value` = MAX: boundary event. `value` ← 0 when SATURATE = 0, or stays MAX when SATURATE = 1.
  - `en` with `up` = 0:
    - If `value` > 0: `value` − 1.
    - If `value` = 0: boundary event. `value` ← MAX when SATURATE = 0, or stays 0 when SATURATE = 1.
  - None of the above: hold `value`, `carry` ← 0.
- On a boundary event: `carry` ← 1 and `ovf` ← 1. This applies in saturate mode as well.
- `carry` is 1 for exactly one cycle per boundary event. Back-to-back events, possible in saturate mode with `en` held, keep `carry` high continuously.
- All arithmetic is performed at WIDTH+1 bits internally, so MAX = 2**WIDTH-1 wraps correctly. `value` never leaves 0..MAX.
- `up` may change on any cycle. No state depends on the previous direction.

## Timing

- Latency is one cycle: inputs sampled at edge N are reflected on `value`, `carry` and `ovf` after edge N.
- No combinational path from any input to any output.
- After reset deassertion, the first rising edge with `reset` = 1 performs the first action.
- `reset` deassertion is assumed to be synchronised externally. The block adds no synchroniser.
- Simultaneous `clear` + `load` + `en`: only the clear is performed.
- Simultaneous `load` + `en`: only the load is performed, with no count and no carry.
- `load` of MAX with `en` = 1 on the following edge and `up` = 1 gives a boundary event on that following edge.

## Structure

- Shared package `counter_pkg` holds:
  - mode constants `CNT_WRAP` = 0 and `CNT_SAT` = 1, used for SATURATE;
  - the helper function `clamp_max`.
- Single module, no sub-module. The next-value logic is one combinational block feeding three registers: `value`, `carry` and `ovf`.

## Test plan

- Parameters WIDTH = 4, MAX = 9, SATURATE = 0, RESET_VALUE = 3. Hold `reset` = 0, release, then run 8 cycles with `en` = 1, `up` = 1. Required:
  - `value` = 3 during reset;
  - sequence 4, 5, 6, 7, 8, 9, 0, 1;
  - `carry` high only in the cycle where `value` = 0;
  - `ovf` = 1 from that cycle on.
- Same parameters, `up` = 0 from `value` = 1. Required: sequence 0, 9, 8, with `carry` high in the cycle showing 9.
- Same parameters with SATURATE = 1: load 8, then 3 cycles with `en` = 1, `up` = 1. Required:
  - `value` sequence 8, 9, 9, 9;
  - `carry` high in the last two cycles;
  - `ovf` sticky until `clear`, then 0 with `value` = 0.
- Load `load_value` = 15 with MAX = 9. Required: `value` = 9.
- Assert `load`, `clear` and `en` together. Required: `value` = 0, `ovf` = 0.
- WIDTH = 8 defaults: count up from 254 with `en` = 1. Required:
  - sequence 255, 0, with `carry` pulsed on the 0;
  - then assert `reset` = 0 asynchronously between edges: `value` = 0, `carry` = 0 and `ovf` = 0 before the next edge.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared definitions for the parametrised counter family.
package counter_pkg;

    localparam bit CNT_WRAP = 1'b0;
    localparam bit CNT_SAT  = 1'b1;

    // Wide enough for any counter up to 32 bits plus the internal carry bit.
    function automatic logic [32:0] clamp_max(input logic [32:0] v, input logic [32:0] max_v);
        return (v > max_v) ? max_v : v;
    endfunction

endpackage

// File: rtl/updown_counter.sv
// Up/down counter with modulus, wrap or saturate mode, sync load/clear,
// registered carry pulse and sticky overflow flag.
module updown_counter
    import counter_pkg::*;
#(
    parameter int unsigned      WIDTH       = 8,
    parameter logic [WIDTH:0]   MAX         = {1'b0, {WIDTH{1'b1}}},
    parameter logic [WIDTH:0]   RESET_VALUE = '0,
    parameter bit               SATURATE    = CNT_WRAP
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             en,
    input  logic             up,
    output logic [WIDTH-1:0] value,
    output logic             carry,
    output logic             ovf
);

    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
        $error("updown_counter: WIDTH must be 2..32");
    end
    if (MAX == '0 || MAX[WIDTH]) begin : g_bad_max
        $error("updown_counter: MAX must be 1..2**WIDTH-1");
    end
    if (RESET_VALUE > MAX) begin : g_bad_reset
        $error("updown_counter: RESET_VALUE exceeds MAX");
    end

    localparam logic [WIDTH:0]   ONE_W = {{WIDTH{1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

    logic [WIDTH-1:0] value_q, value_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH:0]   value_ext;

    assign value_ext = {1'b0, value_q};

    always_comb begin
        value_d = value_q;
        carry_d = 1'b0;
        ovf_d   = ovf_q;
        if (clear) begin
            value_d = '0;
            ovf_d   = 1'b0;
        end else if (load) begin
            value_d = WIDTH'(clamp_max(33'(load_value), 33'(MAX)));
        end else if (en) begin
            if (up) begin
                if (value_ext == MAX) begin
                    value_d = (SATURATE == CNT_SAT) ? value_q : '0;
                    carry_d = 1'b1;
                    ovf_d   = 1'b1;
                end else begin
                    value_d = WIDTH'(value_ext + ONE_W);
                end
            end else begin
                if (value_ext == '0) begin
                    value_d = (SATURATE == CNT_SAT) ? value_q : MAX_V;
                    carry_d = 1'b1;
                    ovf_d   = 1'b1;
                end else begin
                    value_d = WIDTH'(value_ext - ONE_W);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            value_q <= WIDTH'(RESET_VALUE);
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            value_q <= value_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
        end
    end

    assign value = value_q;
    assign carry = carry_q;
    assign ovf   = ovf_q;

endmodule
